// File: rtl/conv2d_pixel_tx.sv
// Frame sender: buffers upstream pixels and streams one frame of IMG_W x IMG_H words with row/frame markers.
// Latency: a pixel accepted on one edge is presented on in_data from the next cycle; one beat per cycle when unstalled.
// Backpressure: in_ready=0 holds the head word; px_in_ready drops while the FIFO is full or the frame quota is accepted.

module conv2d_pixel_tx_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

module conv2d_pixel_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int PIXEL_W    = 24,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PIXEL_W-1:0]    px_in,
  input  logic                  px_in_valid,
  output logic                  px_in_ready,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_valid,
  input  logic                  in_ready,
  output logic                  in_last_col,
  output logic                  in_last_frame,
  output logic                  busy,
  output logic                  done
);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [NW-1:0]     r_accepted;
  logic [NW-1:0]     r_sent;

  logic              w_send;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_col_last;
  logic              w_row_last;
  logic [PIXEL_W-1:0] w_head;

  assign w_send      = (r_state == S_SEND);
  assign px_in_ready = w_send && !w_full && (r_accepted < NW'(TOTAL));
  assign in_valid    = w_send && !w_empty;

  // Abort cancels any handshake in its cycle; the FIFO is flushed instead.
  assign w_push = px_in_valid && px_in_ready && !abort;
  assign w_pop  = in_valid && in_ready && !abort;

  conv2d_pixel_tx_fifo #(
    .W     (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (abort),
    .i_push     (w_push),
    .i_push_dat (px_in),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Data is masked when not valid so stale FIFO storage never leaks after reset or abort.
  assign in_data       = in_valid ? DATA_WIDTH'(w_head) : '0;
  assign w_col_last    = (r_col == CW'(IMG_W - 1));
  assign w_row_last    = (r_row == RW'(IMG_H - 1));
  assign in_last_col   = w_col_last && in_valid;
  assign in_last_frame = in_last_col && w_row_last;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);

  // Frame FSM and position/accept/send counters; reset beats abort, abort beats start and transfers.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_accepted <= '0;
      r_sent     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_SEND;
            r_col      <= '0;
            r_row      <= '0;
            r_accepted <= '0;
            r_sent     <= '0;
          end
        end
        S_SEND: begin
          if (w_push) r_accepted <= r_accepted + 1'b1;
          if (w_pop) begin
            r_sent <= r_sent + 1'b1;
            if (w_col_last) begin
              r_col <= '0;
              r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            // The sent count agrees with the row/col position on the final beat.
            if (in_last_frame && (r_sent == NW'(TOTAL - 1))) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_pixel_tx.sv
module tb_conv2d_pixel_tx;
  localparam int DW = 64;
  localparam int PW = 24;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int FD = 4;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          lc;
    logic          lf;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] px_in = '0;
  logic          px_in_valid = 1'b0;
  logic          px_in_ready;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready = 1'b0;
  logic          in_last_col;
  logic          in_last_frame;
  logic          busy;
  logic          done;

  conv2d_pixel_tx #(
    .DATA_WIDTH (DW),
    .PIXEL_W    (PW),
    .IMG_W      (W),
    .IMG_H      (H),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .px_in         (px_in),
    .px_in_valid   (px_in_valid),
    .px_in_ready   (px_in_ready),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last_col   (in_last_col),
    .in_last_frame (in_last_frame),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  beat_t         exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            acc_idx = 0;
  int            beats = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  int            d0 = 0;
  bit            done_exp = 1'b0;
  bit            prev_stall = 1'b0;
  bit            stop_drv = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: done pulse, hold-stability, beat compare, then record new accepts.
  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      chk("done_pulse", {63'd0, done}, {63'd0, done_exp});
      if (done === 1'b1) done_cnt++;
      done_exp = 1'b0;
      if (prev_stall) begin
        chk("hold_valid", {63'd0, in_valid}, 64'd1);
        chk("hold_data", in_data, prev_dat);
      end
      prev_stall = (in_valid === 1'b1) && !in_ready && !rst && !abort;
      prev_dat   = in_data;
      if ((in_valid === 1'b1) && in_ready && !rst && !abort) begin
        beats++;
        if (beats == 1) first_cyc = cyc;
        last_cyc = cyc;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got dat=%0h, want no beat", in_data);
        end else begin
          e = exp_q.pop_front();
          if ({in_data, in_last_col, in_last_frame} !== {e.dat, e.lc, e.lf}) begin
            n_err++;
            $display("FAIL beat%0d: got dat=%0h lc=%b lf=%b, want dat=%0h lc=%b lf=%b",
                     beats, in_data, in_last_col, in_last_frame, e.dat, e.lc, e.lf);
          end
          done_exp = e.lf;
        end
      end
      if (px_in_valid && (px_in_ready === 1'b1) && !rst && !abort) begin
        e.dat = DW'(px_in);
        e.lc  = ((acc_idx % W) == W - 1);
        e.lf  = (acc_idx == W * H - 1);
        exp_q.push_back(e);
        acc_idx++;
      end
    end
  endtask

  task automatic drive_px(input int n, input int base);
    int t;
    for (int i = 0; i < n; i++) begin
      px_in       = PW'(base + i);
      px_in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (px_in_ready !== 1'b1 && !stop_drv && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (stop_drv) break;
      if (t >= 200) begin
        n_vec++;
        n_err++;
        $display("FAIL px_accept_timeout: got no accept, want accept of pixel %0d", base + i);
        break;
      end
      tick();
    end
    px_in_valid = 1'b0;
  endtask

  task automatic start_frame();
    acc_idx = 0;
    beats   = 0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (t >= 200) begin
      n_err++;
      $display("FAIL %s: got no done within 200 cycles, want done", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_outputs", {58'd0, px_in_ready, in_valid, in_last_col, in_last_frame, busy, done}, 64'd0);
    chk("rst_in_data", in_data, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_outputs", {58'd0, px_in_ready, in_valid, in_last_col, in_last_frame, busy, done}, 64'd0);

    // Full frame, both sides ready
    in_ready = 1'b1;
    start_frame();
    chk("t1_busy_send", {63'd0, busy}, 64'd1);
    drive_px(8, 1);
    wait_done("t1_done");
    chk("t1_beats", beats, 8);
    chk("t1_spacing", last_cyc - first_cyc, 7);
    tick();
    chk("t1_idle_busy", {63'd0, busy}, 64'd0);

    // Backpressure mid-frame
    start_frame();
    fork
      drive_px(8, 11);
      begin
        repeat (3) @(posedge clk);
        #1 in_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_full_rdy", {63'd0, px_in_ready}, 64'd0);
        chk("bp_valid", {63'd0, in_valid}, 64'd1);
        chk("bp_head", in_data, 64'd13);
        @(posedge clk);
        #1 in_ready = 1'b1;
      end
    join
    wait_done("t2_done");
    chk("t2_beats", beats, 8);
    tick();

    // Over-supply
    d0 = done_cnt;
    start_frame();
    drive_px(8, 21);
    px_in_valid = 1'b1;
    px_in       = 24'd99;
    repeat (6) begin
      @(negedge clk);
      chk("os_rdy_low", {63'd0, px_in_ready}, 64'd0);
    end
    tick();
    px_in_valid = 1'b0;
    chk("os_accepted", acc_idx, 8);
    chk("os_done_cnt", done_cnt - d0, 1);

    // Abort after beat 3
    d0 = done_cnt;
    start_frame();
    fork
      drive_px(8, 31);
      begin
        int t;
        t = 0;
        while (beats < 3 && t < 200) begin
          @(negedge clk);
          #1;
          t++;
        end
        @(posedge clk);
        #1 abort = 1'b1;
        stop_drv = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("ab_valid", {63'd0, in_valid}, 64'd0);
        chk("ab_busy", {63'd0, busy}, 64'd0);
        chk("ab_beats", beats, 3);
      end
    join
    stop_drv = 1'b0;
    repeat (4) tick();
    chk("ab_no_done", done_cnt - d0, 0);
    start_frame();
    drive_px(8, 41);
    wait_done("t4_done");
    chk("t4_beats", beats, 8);
    tick();

    // Reset mid-frame with two buffered pixels
    in_ready = 1'b0;
    start_frame();
    drive_px(2, 51);
    rst      = 1'b1;
    in_ready = 1'b1;
    tick();
    exp_q.delete();
    @(negedge clk);
    chk("rm_outputs", {58'd0, px_in_ready, in_valid, in_last_col, in_last_frame, busy, done}, 64'd0);
    chk("rm_in_data", in_data, 64'd0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("rm_no_beats", beats, 0);

    // start during SEND is ignored
    d0 = done_cnt;
    start_frame();
    fork
      drive_px(8, 61);
      begin
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    wait_done("t6_done");
    repeat (3) tick();
    chk("t6_done_cnt", done_cnt - d0, 1);
    chk("t6_beats", beats, 8);
    chk("q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/conv2d_pixel_tx.md
CONV2D_PIXEL_TX -- requirements
Module: conv2d_pixel_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the output stream word width.
REQ-002 SHALL have parameter PIXEL_W, default 24, the packed pixel width; PIXEL_W <= DATA_WIDTH.
REQ-003 SHALL have parameters IMG_W, default 32, and IMG_H, default 32, the frame columns and rows.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, a power of 2 and >= 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle frame start request.
REQ-008 SHALL have port abort, input, 1 bit: synchronous frame abort.
REQ-009 SHALL have port px_in, input, PIXEL_W bits: upstream pixel data.
REQ-010 SHALL have port px_in_valid, input, 1 bit: upstream pixel valid.
REQ-011 SHALL have port px_in_ready, output, 1 bit: this block accepts a pixel.
REQ-012 SHALL have port in_data, output, DATA_WIDTH bits: stream word toward the conv2d input adaptor.
REQ-013 SHALL have port in_valid, output, 1 bit: stream word valid.
REQ-014 SHALL have port in_ready, input, 1 bit: downstream accepts the word.
REQ-015 SHALL have port in_last_col, output, 1 bit: current word is the last pixel of a row.
REQ-016 SHALL have port in_last_frame, output, 1 bit: current word is the last pixel of the frame.
REQ-017 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-019 SHALL implement FSM IDLE -> SEND -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-020 In IDLE, start=1 SHALL enter SEND next cycle and clear the column/row, accepted, and sent counters; start is ignored outside IDLE.
REQ-021 px_in_ready SHALL be 1 only when: state is SEND, FIFO is not full, and accepted count < IMG_W*IMG_H; a pixel is pushed when px_in_valid && px_in_ready.
REQ-022 in_valid SHALL equal (state==SEND && FIFO not empty); in_data SHALL be the FIFO head pixel, zero-extended to DATA_WIDTH.
REQ-023 A beat SHALL transfer when in_valid && in_ready; the FIFO pops and the sent counter increments.
REQ-024 While in_valid && !in_ready, in_data, in_last_col, and in_last_frame SHALL hold stable, and in_valid SHALL stay 1.
REQ-025 Column counter SHALL increment per beat and wrap from IMG_W-1 to 0; the row counter SHALL increment on that wrap.
REQ-026 in_last_col SHALL be (col==IMG_W-1) && in_valid; in_last_frame SHALL be in_last_col && (row==IMG_H-1).
REQ-027 A transfer with in_last_frame=1 SHALL move the FSM to DONE; done=1 in DONE only.
REQ-028 Push and pop in the same cycle SHALL both occur, leaving occupancy unchanged; a push into a full FIFO SHALL be impossible (REQ-021).
REQ-029 No pass-through: a pixel pushed in cycle N SHALL appear on in_data no earlier than cycle N+1 (minimum latency 1 cycle).
REQ-030 Sustained throughput with both sides always ready SHALL be 1 beat per cycle after the first.
REQ-031 abort=1 in any state SHALL, next cycle, force IDLE, flush the FIFO, clear counters, and leave done=0; abort overrides start and transfers in the same cycle.
REQ-032 busy SHALL be 1 in SEND and DONE and 0 in IDLE.

Reset
REQ-033 rst=1 SHALL, at the next edge, force IDLE, empty the FIFO, and zero all counters; rst overrides abort and start.
REQ-034 During and after reset: px_in_ready=0, in_valid=0, in_data=0, in_last_col=0, in_last_frame=0, busy=0, done=0.
REQ-035 Reset asserted mid-frame SHALL discard all buffered pixels; no beat from that frame appears after reset.

Verification
REQ-036 Full frame, IMG_W=4, IMG_H=2, both sides always ready, pixels 1..8 -> 8 beats in order 1..8; in_last_col on beats 4 and 8; in_last_frame on beat 8 only; done pulses 1 cycle after beat 8.
REQ-037 Backpressure: in_ready=0 for 5 cycles starting mid-frame -> in_data stable at the same value throughout; FIFO fills to 4; px_in_ready=0 while full; no loss or duplication.
REQ-038 Over-supply: upstream keeps px_in_valid=1 past 8 pixels -> exactly 8 accepted; px_in_ready=0 after the 8th accept.
REQ-039 Abort after beat 3 -> next cycle IDLE, in_valid=0, done never asserts; a new start then sends pixels with col=0, row=0.
REQ-040 Reset mid-frame with FIFO holding 2 pixels -> all outputs 0 the next cycle; those 2 pixels are never emitted.
REQ-041 start asserted during SEND -> ignored; the frame completes normally with one done pulse.
